vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing generator: successor to the fixed-mode vga_timing feeding draw_background.
//  Produces h/v counters, sync pulses with selectable polarity, blanking, data-enable,
//  line/frame start strobes and a frame counter. Any mode is set by parameters.
//  Optional clock enable allows a pixel rate below pclk.
//  Sits at the head of the pclk pipeline; outputs drive draw_background unchanged.
// PARAMETERS
//  H_ACTIVE  1024  visible pixels per line
//  H_FP      24    horizontal front porch, pixels
//  H_SYNC    136   hsync pulse width, pixels
//  H_BP      144   horizontal back porch, pixels (H_TOTAL = sum = 1328)
//  V_ACTIVE  768   visible lines per frame
//  V_FP      3     vertical front porch, lines
//  V_SYNC    6     vsync pulse width, lines
//  V_BP      29    vertical back porch, lines (V_TOTAL = sum = 806)
//  H_POL     0     hsync level while pulse active (0 = negative sync)
//  V_POL     0     vsync level while pulse active
//  CNT_W     11    counter width; 2**CNT_W must exceed H_TOTAL-1 and V_TOTAL-1
//  FCNT_W    16    frame counter width
// PORTS
//  pclk         in   1       pixel clock
//  rst          in   1       synchronous reset, active-low
//  ce           in   1       pixel enable; counters advance only when 1
//  hcount       out  CNT_W   horizontal position, 0..H_TOTAL-1
//  vcount       out  CNT_W   vertical position, 0..V_TOTAL-1
//  hsync        out  1       horizontal sync, level per H_POL
//  vsync        out  1       vertical sync, level per V_POL
//  hblnk        out  1       1 when hcount >= H_ACTIVE
//  vblnk        out  1       1 when vcount >= V_ACTIVE
//  de           out  1       ~hblnk & ~vblnk
//  line_start   out  1       1-cycle strobe, hcount==0 on a ce cycle
//  frame_start  out  1       1-cycle strobe, hcount==0 && vcount==0 on a ce cycle
//  frame_cnt    out  FCNT_W  completed frames, wraps modulo 2**FCNT_W
// BEHAVIOUR
//  - All outputs registered; every flag decoded from the count values presented the same cycle (zero skew).
//  - rst==0 at pclk edge: hcount=vcount=0, frame_cnt=0, hblnk=vblnk=0, de=1,
//    hsync=~H_POL, vsync=~V_POL, line_start=frame_start=0. Applies mid-line; no partial line kept.
//  - First ce after reset release presents hcount=0,vcount=0 unchanged, line_start=frame_start=1.
//    Thereafter each ce cycle: hcount+1; at H_TOTAL-1 -> 0 and vcount+1; vcount at V_TOTAL-1 -> 0.
//  - ce==0: counts, syncs, blanks, de, frame_cnt hold; line_start/frame_start forced 0.
//  - hsync active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; else ~H_POL.
//  - vsync active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], full lines (changes with hcount==0).
//  - frame_cnt increments on the wrap hcount H_TOTAL-1->0 with vcount V_TOTAL-1->0; 2**FCNT_W-1 wraps to 0.
//  - Counter arithmetic in CNT_W bits; compare bounds computed as CNT_W+1-bit constants, no overflow.
//  - Elaboration: illegal params (any width 0, totals not fitting CNT_W) halt via $error in generate.
//  - Simultaneous rst==0 and ce==1: reset wins.
// TESTING
//  1 Defaults, ce=1, run 2 frames: line_start every 1328 cycles, frame_start every 1328*806=1070368.
//  2 Defaults: hsync=0 exactly for hcount 1048..1183; vsync=0 for vcount 771..776; hblnk at 1024, vblnk at 768.
//  3 ce toggled 1-of-2: period doubles (2656 cycles/line); outputs hold on ce=0; strobes only on ce=1.
//  4 rst=0 at hcount=500,vcount=300 for 1 cycle: next cycle counts 0/0, syncs idle, frame_cnt=0.
//  5 H_POL=1,V_POL=1, small mode 8/2/2/2 x 4/1/1/1: hsync=1 for hcount 10..11, vsync=1 for vcount 5; H_TOTAL=14.
//  6 FCNT_W=2: after 4 frames frame_cnt wraps 3->0 on the frame_start cycle; de matches ~hblnk&~vblnk throughout.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                             |
// | Description : Parametrised VGA timing generator. Produces horizontal and |
// |               vertical counters, sync pulses of selectable polarity,     |
// |               blanking, data-enable, line/frame start strobes and a      |
// |               completed-frame counter. Counting advances only on cycles  |
// |               with ce=1, so the pixel rate may be a fraction of pclk.    |
// | Ports       : pclk        pixel clock                                    |
// |               rst         synchronous reset, active-low                  |
// |               ce          pixel enable                                   |
// |               hcount      horizontal position 0..H_TOTAL-1               |
// |               vcount      vertical position 0..V_TOTAL-1                 |
// |               hsync/vsync sync outputs, active level H_POL/V_POL         |
// |               hblnk/vblnk blanking flags                                 |
// |               de          data enable (~hblnk & ~vblnk)                  |
// |               line_start  strobe when hcount==0 on a ce cycle            |
// |               frame_start strobe when hcount==0 && vcount==0 on ce       |
// |               frame_cnt   completed frames, wraps modulo 2**FCNT_W       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 144,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 11,
    parameter int FCNT_W   = 16
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              ce,
    output logic [CNT_W-1:0]  hcount,
    output logic [CNT_W-1:0]  vcount,
    output logic              hsync,
    output logic              vsync,
    output logic              hblnk,
    output logic              vblnk,
    output logic              de,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt
);

    localparam int c_h_total_i = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total_i = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Bounds carry one extra bit so that an end bound equal to 2**CNT_W
    // (sync pulse running to the very last count) is still representable.
    localparam logic [CNT_W:0] c_h_last   = (CNT_W+1)'(c_h_total_i - 1);
    localparam logic [CNT_W:0] c_v_last   = (CNT_W+1)'(c_v_total_i - 1);
    localparam logic [CNT_W:0] c_h_active = (CNT_W+1)'(H_ACTIVE);
    localparam logic [CNT_W:0] c_v_active = (CNT_W+1)'(V_ACTIVE);
    localparam logic [CNT_W:0] c_hs_beg   = (CNT_W+1)'(H_ACTIVE + H_FP);
    localparam logic [CNT_W:0] c_hs_end   = (CNT_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W:0] c_vs_beg   = (CNT_W+1)'(V_ACTIVE + V_FP);
    localparam logic [CNT_W:0] c_vs_end   = (CNT_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (CNT_W < 1 || CNT_W > 30 || FCNT_W < 1 ||
            H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
            H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_width
            $error("vga_timing_gen: zero or negative width parameter");
        end
        if (CNT_W >= 1 && CNT_W <= 30 &&
            (c_h_total_i > (1 << CNT_W) || c_v_total_i > (1 << CNT_W))) begin : g_bad_range
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
        end
    endgenerate

    // Cleared by reset: the first enabled cycle afterwards presents 0/0
    // with strobes instead of advancing, so the frame restarts cleanly.
    logic r_started;

    logic [CNT_W-1:0] w_h_next;
    logic [CNT_W-1:0] w_v_next;
    logic             w_frame_wrap;
    logic [CNT_W:0]   w_h_ext;
    logic [CNT_W:0]   w_v_ext;
    logic             w_hblnk;
    logic             w_vblnk;
    logic             w_hs_on;
    logic             w_vs_on;

    always_comb begin
        w_h_next     = hcount;
        w_v_next     = vcount;
        w_frame_wrap = 1'b0;
        if (r_started) begin
            if ({1'b0, hcount} == c_h_last) begin
                w_h_next = '0;
                if ({1'b0, vcount} == c_v_last) begin
                    w_v_next     = '0;
                    w_frame_wrap = 1'b1;
                end else begin
                    w_v_next = vcount + CNT_W'(1);
                end
            end else begin
                w_h_next = hcount + CNT_W'(1);
            end
        end
    end

    // Flags are decoded from the next counts and registered alongside
    // them, so every output refers to the same pixel position.
    always_comb begin
        w_h_ext = {1'b0, w_h_next};
        w_v_ext = {1'b0, w_v_next};
        w_hblnk = (w_h_ext >= c_h_active);
        w_vblnk = (w_v_ext >= c_v_active);
        w_hs_on = (w_h_ext >= c_hs_beg) && (w_h_ext < c_hs_end);
        w_vs_on = (w_v_ext >= c_vs_beg) && (w_v_ext < c_vs_end);
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_started   <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            de          <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else if (ce) begin
            r_started   <= 1'b1;
            hcount      <= w_h_next;
            vcount      <= w_v_next;
            hsync       <= w_hs_on ? H_POL : ~H_POL;
            vsync       <= w_vs_on ? V_POL : ~V_POL;
            hblnk       <= w_hblnk;
            vblnk       <= w_vblnk;
            de          <= ~w_hblnk & ~w_vblnk;
            line_start  <= (w_h_next == '0);
            frame_start <= (w_h_next == '0) && (w_v_next == '0);
            if (w_frame_wrap) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                          |
// | Description : Self-checking bench for vga_timing_gen. Three instances:   |
// |               default 1024x768 mode, a tiny positive-sync mode and a     |
// |               small mode with a 2-bit frame counter. A pixel-index model |
// |               gives expected outputs with plain division/modulo.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic [15:0] fc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        de;
        logic        ls;
        logic        fs;
    } snap_t;

    // Mode tables: index 0 = default mode, 1 = tiny positive-sync mode,
    // 2 = small mode with CNT_W at its limit and a 2-bit frame counter.
    int c_ha  [3] = '{1024, 8, 20};
    int c_hfp [3] = '{24,   2, 3};
    int c_hs  [3] = '{136,  2, 5};
    int c_hbp [3] = '{144,  2, 4};
    int c_va  [3] = '{768,  4, 10};
    int c_vfp [3] = '{3,    1, 2};
    int c_vs  [3] = '{6,    1, 3};
    int c_vbp [3] = '{29,   1, 2};
    int c_fw  [3] = '{16,  16, 2};
    bit c_hpol[3] = '{1'b0, 1'b1, 1'b0};
    bit c_vpol[3] = '{1'b0, 1'b1, 1'b0};

    logic       pclk = 1'b0;
    logic [2:0] rst_b;
    logic [2:0] ce_b;

    logic [10:0] hc0, vc0;
    logic [15:0] fc0;
    logic        hs0, vs0, hb0, vb0, de0, ls0, fs0;
    logic [3:0]  hc1, vc1;
    logic [15:0] fc1;
    logic        hs1, vs1, hb1, vb1, de1, ls1, fs1;
    logic [4:0]  hc2, vc2;
    logic [1:0]  fc2;
    logic        hs2, vs2, hb2, vb2, de2, ls2, fs2;

    int n_cmp;
    int n_err;

    // Reference model state: pixels advanced since reset, plus strobes.
    longint m_p [3];
    bit     m_started [3];
    bit     m_ls [3];
    bit     m_fs [3];

    always #5 pclk = ~pclk;

    vga_timing_gen dut0 (
        .pclk(pclk), .rst(rst_b[0]), .ce(ce_b[0]),
        .hcount(hc0), .vcount(vc0), .hsync(hs0), .vsync(vs0),
        .hblnk(hb0), .vblnk(vb0), .de(de0),
        .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4), .FCNT_W(16)
    ) dut1 (
        .pclk(pclk), .rst(rst_b[1]), .ce(ce_b[1]),
        .hcount(hc1), .vcount(vc1), .hsync(hs1), .vsync(vs1),
        .hblnk(hb1), .vblnk(vb1), .de(de1),
        .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b0), .V_POL(1'b0), .CNT_W(5), .FCNT_W(2)
    ) dut2 (
        .pclk(pclk), .rst(rst_b[2]), .ce(ce_b[2]),
        .hcount(hc2), .vcount(vc2), .hsync(hs2), .vsync(vs2),
        .hblnk(hb2), .vblnk(vb2), .de(de2),
        .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
    );

    function automatic int htot(int d);
        return c_ha[d] + c_hfp[d] + c_hs[d] + c_hbp[d];
    endfunction

    function automatic int vtot(int d);
        return c_va[d] + c_vfp[d] + c_vs[d] + c_vbp[d];
    endfunction

    function automatic snap_t obs(int d);
        snap_t s;
        s = '0;
        case (d)
            0: s = '{h:16'(hc0), v:16'(vc0), fc:fc0, hs:hs0, vs:vs0,
                     hb:hb0, vb:vb0, de:de0, ls:ls0, fs:fs0};
            1: s = '{h:16'(hc1), v:16'(vc1), fc:fc1, hs:hs1, vs:vs1,
                     hb:hb1, vb:vb1, de:de1, ls:ls1, fs:fs1};
            2: s = '{h:16'(hc2), v:16'(vc2), fc:16'(fc2), hs:hs2, vs:vs2,
                     hb:hb2, vb:vb2, de:de2, ls:ls2, fs:fs2};
            default: s = '0;
        endcase
        return s;
    endfunction

    // Expected outputs from the pixel index: position is index modulo the
    // line/frame lengths, frames completed is index divided by frame size.
    function automatic snap_t expv(int d);
        snap_t  s;
        longint h;
        longint v;
        longint hs_b;
        longint vs_b;
        h    = m_p[d] % htot(d);
        v    = (m_p[d] / htot(d)) % vtot(d);
        hs_b = c_ha[d] + c_hfp[d];
        vs_b = c_va[d] + c_vfp[d];
        s    = '0;
        s.h  = 16'(h);
        s.v  = 16'(v);
        s.fc = 16'((m_p[d] / (htot(d) * vtot(d))) % (longint'(1) << c_fw[d]));
        s.hb = (h >= c_ha[d]);
        s.vb = (v >= c_va[d]);
        s.de = !s.hb && !s.vb;
        s.hs = (h >= hs_b && h < hs_b + c_hs[d]) ? c_hpol[d] : ~c_hpol[d];
        s.vs = (v >= vs_b && v < vs_b + c_vs[d]) ? c_vpol[d] : ~c_vpol[d];
        s.ls = m_ls[d];
        s.fs = m_fs[d];
        return s;
    endfunction

    function automatic snap_t reset_snap(int d);
        snap_t s;
        s    = '0;
        s.hs = ~c_hpol[d];
        s.vs = ~c_vpol[d];
        s.de = 1'b1;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("h=%0d v=%0d fc=%0d hs=%0b vs=%0b hb=%0b vb=%0b de=%0b ls=%0b fs=%0b",
                         s.h, s.v, s.fc, s.hs, s.vs, s.hb, s.vb, s.de, s.ls, s.fs);
    endfunction

    // One pclk edge; the model consumes the same rst/ce the DUTs sampled.
    task automatic step();
        @(posedge pclk);
        for (int d = 0; d < 3; d++) begin
            if (!rst_b[d]) begin
                m_p[d] = 0; m_started[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
            end else if (ce_b[d]) begin
                if (m_started[d]) m_p[d] = m_p[d] + 1;
                m_started[d] = 1'b1;
                m_ls[d] = ((m_p[d] % htot(d)) == 0);
                m_fs[d] = ((m_p[d] % (htot(d) * vtot(d))) == 0);
            end else begin
                m_ls[d] = 1'b0; m_fs[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_b = 3'b000;
        ce_b  = 3'b111;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== reset_snap(d)) begin
                n_err++;
                $display("FAIL reset dut%0d: got %s, expected %s", d, fmt(obs(d)), fmt(reset_snap(d)));
            end
        end
    endtask

    task automatic test_first_ce();
        snap_t e;
        rst_b = 3'b111;
        ce_b  = 3'b000;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            n_cmp++;
            if (obs(d) !== reset_snap(d)) begin
                n_err++;
                $display("FAIL idle_after_reset dut%0d: got %s, expected %s", d, fmt(obs(d)), fmt(reset_snap(d)));
            end
        end
        ce_b = 3'b111;
        step();
        for (int d = 0; d < 3; d++) begin
            e = reset_snap(d); e.ls = 1'b1; e.fs = 1'b1;
            n_cmp++;
            if (obs(d) !== e) begin
                n_err++;
                $display("FAIL first_ce dut%0d: got %s, expected %s", d, fmt(obs(d)), fmt(e));
            end
        end
        step();
        for (int d = 0; d < 3; d++) begin
            e = reset_snap(d); e.h = 16'd1;
            n_cmp++;
            if (obs(d) !== e) begin
                n_err++;
                $display("FAIL second_ce dut%0d: got %s, expected %s", d, fmt(obs(d)), fmt(e));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 3; d++) begin
                ce_b[d]  = ($urandom_range(0, 3) != 0);
                rst_b[d] = ($urandom_range(0, 299) != 0);
            end
            step();
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if (obs(d) !== expv(d)) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc%0d: got %s, expected %s", d, c, fmt(obs(d)), fmt(expv(d)));
                end
            end
        end
        rst_b = 3'b111;
        ce_b  = 3'b111;
    endtask

    task automatic test_line_timing();
        snap_t s;
        int    gap, lo_min, lo_max, lo_cnt, hb_first;
        bit    done;
        done = 1'b0;
        for (int i = 0; i < 1400 && !done; i++) begin
            step();
            if (obs(0).ls) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL line_align: got no line_start, expected one within 1400 cycles"); end
        for (int ln = 0; ln < 2; ln++) begin
            lo_min = 99999; lo_max = -1; lo_cnt = 0; hb_first = -1; gap = 0; done = 1'b0;
            while (!done && gap < 1400) begin
                s = obs(0);
                if (s.hs == 1'b0) begin
                    lo_cnt++;
                    if (int'(s.h) < lo_min) lo_min = int'(s.h);
                    if (int'(s.h) > lo_max) lo_max = int'(s.h);
                end
                if (s.hb && hb_first < 0) hb_first = int'(s.h);
                step();
                gap++;
                if (obs(0).ls) done = 1'b1;
            end
            n_cmp++;
            if (gap != 1328) begin n_err++; $display("FAIL line_period: got %0d, expected 1328", gap); end
            n_cmp++;
            if (lo_min != 1048 || lo_max != 1183 || lo_cnt != 136) begin
                n_err++;
                $display("FAIL hsync_window: got %0d..%0d n=%0d, expected 1048..1183 n=136", lo_min, lo_max, lo_cnt);
            end
            n_cmp++;
            if (hb_first != 1024) begin n_err++; $display("FAIL hblnk_start: got %0d, expected 1024", hb_first); end
        end
    endtask

    task automatic test_ce_half();
        snap_t prev, e;
        int    gap;
        bit    done;
        ce_b = 3'b111;
        done = 1'b0;
        for (int i = 0; i < 1400 && !done; i++) begin
            step();
            if (obs(0).ls) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL ce_half_align: got no line_start, expected one within 1400 cycles"); end
        for (int ln = 0; ln < 2; ln++) begin
            gap = 0; done = 1'b0;
            while (!done && gap < 3000) begin
                prev = obs(0);
                ce_b[0] = ~ce_b[0];
                step();
                gap++;
                if (!ce_b[0]) begin
                    e = prev; e.ls = 1'b0; e.fs = 1'b0;
                    n_cmp++;
                    if (obs(0) !== e) begin
                        n_err++;
                        $display("FAIL ce_hold: got %s, expected %s", fmt(obs(0)), fmt(e));
                    end
                end
                if (obs(0).ls) done = 1'b1;
            end
            n_cmp++;
            if (gap != 2656) begin n_err++; $display("FAIL ce_half_period: got %0d, expected 2656", gap); end
        end
        ce_b = 3'b111;
    endtask

    task automatic test_small_pol();
        snap_t s, prev;
        int    gap, hmin, hmax, hcnt, vmin, vmax, vcnt, lgap, lmin;
        bit    done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (obs(1).fs) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL small_align: got no frame_start, expected one within 200 cycles"); end
        hmin = 99; hmax = -1; hcnt = 0; vmin = 99; vmax = -1; vcnt = 0;
        gap = 0; lgap = 0; lmin = 999; done = 1'b0;
        while (!done && gap < 200) begin
            s = obs(1);
            if (s.hs) begin hcnt++; if (int'(s.h) < hmin) hmin = int'(s.h); if (int'(s.h) > hmax) hmax = int'(s.h); end
            if (s.vs) begin vcnt++; if (int'(s.v) < vmin) vmin = int'(s.v); if (int'(s.v) > vmax) vmax = int'(s.v); end
            prev = s;
            step();
            gap++;
            lgap++;
            s = obs(1);
            if (s.ls) begin if (lgap < lmin) lmin = lgap; lgap = 0; end
            n_cmp++;
            if (s.vs != prev.vs && s.h != 16'd0) begin
                n_err++;
                $display("FAIL vsync_edge: got vsync change at h=%0d, expected only at h=0", s.h);
            end
            if (s.fs) done = 1'b1;
        end
        n_cmp++;
        if (gap != 98) begin n_err++; $display("FAIL small_frame_period: got %0d, expected 98", gap); end
        n_cmp++;
        if (lmin != 14) begin n_err++; $display("FAIL small_line_period: got %0d, expected 14", lmin); end
        n_cmp++;
        if (hmin != 10 || hmax != 11 || hcnt != 14) begin
            n_err++;
            $display("FAIL small_hsync: got %0d..%0d n=%0d, expected 10..11 n=14", hmin, hmax, hcnt);
        end
        n_cmp++;
        if (vmin != 5 || vmax != 5 || vcnt != 14) begin
            n_err++;
            $display("FAIL small_vsync: got %0d..%0d n=%0d, expected 5..5 n=14", vmin, vmax, vcnt);
        end
    endtask

    task automatic test_fcnt_wrap();
        snap_t s;
        int    prev_fc, exp_fc, frames, cyc;
        bit    done, saw_wrap;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            if (obs(2).fs) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL fcnt_align: got no frame_start, expected one within 600 cycles"); end
        prev_fc = int'(obs(2).fc);
        frames = 0; cyc = 0; saw_wrap = 1'b0;
        while (frames < 6 && cyc < 6 * 544 + 50) begin
            step();
            cyc++;
            s = obs(2);
            exp_fc = s.fs ? (prev_fc + 1) % 4 : prev_fc;
            n_cmp++;
            if (int'(s.fc) != exp_fc) begin
                n_err++;
                $display("FAIL frame_cnt: got %0d, expected %0d (fs=%0b)", s.fc, exp_fc, s.fs);
            end
            n_cmp++;
            if (s.de !== (~s.hb & ~s.vb)) begin
                n_err++;
                $display("FAIL de_consistency: got de=%0b, expected %0b", s.de, ~s.hb & ~s.vb);
            end
            if (s.fs) begin
                if (prev_fc == 3) saw_wrap = 1'b1;
                frames++;
            end
            prev_fc = exp_fc;
        end
        n_cmp++;
        if (frames != 6 || !saw_wrap) begin
            n_err++;
            $display("FAIL fcnt_frames: got frames=%0d wrap=%0b, expected frames=6 wrap=1", frames, saw_wrap);
        end
    endtask

    task automatic test_mid_reset();
        snap_t e;
        bit    done;
        done = 1'b0;
        for (int i = 0; i < 1400 && !done; i++) begin
            step();
            if (obs(0).h == 16'd500) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL mid_align: got no h=500, expected within 1400 cycles"); end
        rst_b[0] = 1'b0;
        step();
        rst_b[0] = 1'b1;
        n_cmp++;
        if (obs(0) !== reset_snap(0)) begin
            n_err++;
            $display("FAIL mid_reset: got %s, expected %s", fmt(obs(0)), fmt(reset_snap(0)));
        end
        step();
        e = reset_snap(0); e.ls = 1'b1; e.fs = 1'b1;
        n_cmp++;
        if (obs(0) !== e) begin
            n_err++;
            $display("FAIL mid_restart: got %s, expected %s", fmt(obs(0)), fmt(e));
        end
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            step();
            if (obs(2).v == 16'd9 && obs(2).fc != 16'd0) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL fc_align: got no v=9 with fc!=0, expected within 600 cycles"); end
        rst_b[2] = 1'b0;
        step();
        rst_b[2] = 1'b1;
        n_cmp++;
        if (obs(2) !== reset_snap(2)) begin
            n_err++;
            $display("FAIL mid_reset_fc: got %s, expected %s", fmt(obs(2)), fmt(reset_snap(2)));
        end
        step();
        n_cmp++;
        if (obs(2) !== expv(2)) begin
            n_err++;
            $display("FAIL post_reset_model: got %s, expected %s", fmt(obs(2)), fmt(expv(2)));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_b = 3'b000;
        ce_b  = 3'b000;
        for (int d = 0; d < 3; d++) begin
            m_p[d] = 0; m_started[d] = 1'b0; m_ls[d] = 1'b0; m_fs[d] = 1'b0;
        end
        test_reset();
        test_first_ce();
        test_random();
        test_line_timing();
        test_ce_half();
        test_small_pol();
        test_fcnt_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running at 5 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
